// File: rtl/time_setup_ctrl_pkg.sv
// Shared definitions for the time-setting controller: FSM state encoding,
// default timing constants and the setup-field rotation helper.
package time_setup_ctrl_pkg;

    localparam int unsigned DEF_TICK_DIV        = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned DEF_REPEAT_RATE     = 5_000_000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_SEC  = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_t;

    // Select rotates seconds -> minutes -> hours -> seconds.
    function automatic state_t next_field(input state_t s);
        case (s)
            ST_SET_SEC: return ST_SET_MIN;
            ST_SET_MIN: return ST_SET_HOUR;
            default:    return ST_SET_SEC;
        endcase
    endfunction

endpackage

// File: rtl/time_setup_ctrl_btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, debounce counter that accepts
// a new level after DEBOUNCE_CYCLES equal samples, and a one-cycle press pulse.
module btn_debounce
    import time_setup_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // The sample that completes the run is the one accepted.
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_setup_ctrl.sv
// Clock time-setting controller: run/setup FSM, 1 Hz timebase in run mode,
// and single/auto-repeat adjust pulses with direction in setup mode.
module time_setup_ctrl
    import time_setup_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode,
    input  logic btn_select,
    input  logic btn_up,
    input  logic btn_down,
    output logic display,
    output logic setup_second,
    output logic setup_minute,
    output logic setup_hour,
    output logic inc_dec,
    output logic tick
);

    localparam int unsigned TB_W = $clog2(TICK_DIV + 1);
    localparam int unsigned RW   = $clog2(REPEAT_DELAY + 1);
    localparam logic [TB_W-1:0] TB_LAST    = TB_W'(TICK_DIV - 1);
    localparam logic [RW-1:0]   REP_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

    logic mode_lvl, mode_press;
    logic sel_lvl, sel_press;
    logic up_lvl, up_press;
    logic dn_lvl, dn_press;
    logic unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .btn(btn_mode), .level(mode_lvl), .press(mode_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
        .clk(clk), .rst(rst), .btn(btn_select), .level(sel_lvl), .press(sel_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .btn(btn_up), .level(up_lvl), .press(up_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .btn(btn_down), .level(dn_lvl), .press(dn_press)
    );

    // Mode and select only act on press edges; their held levels are unused.
    assign unused_levels = mode_lvl ^ sel_lvl;

    state_t state, state_next;
    logic   state_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (mode_press) begin
            state_next = (state == ST_RUN) ? ST_SET_SEC : ST_RUN;
        end else if (sel_press && state != ST_RUN) begin
            state_next = next_field(state);
        end
    end

    assign state_change = (state_next != state);
    assign display      = (state != ST_RUN);
    assign setup_second = (state != ST_SET_SEC);
    assign setup_minute = (state != ST_SET_MIN);
    assign setup_hour   = (state != ST_SET_HOUR);

    logic [TB_W-1:0] tb_cnt;
    logic            run_tick;

    // Held at zero through setup and on the transition edges, so run mode
    // always restarts a full TICK_DIV period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_cnt <= '0;
        end else if (state != ST_RUN || state_next != ST_RUN) begin
            tb_cnt <= '0;
        end else if (tb_cnt == TB_LAST) begin
            tb_cnt <= '0;
        end else begin
            tb_cnt <= tb_cnt + 1'b1;
        end
    end

    assign run_tick = (state == ST_RUN) && (tb_cnt == TB_LAST);

    logic          adj_tick;
    logic          rep_active;
    logic [RW-1:0] rep_cnt;
    logic          held_lvl;

    assign held_lvl = inc_dec ? up_lvl : dn_lvl;

    // rep_cnt counts cycles since the press; reloading below REP_LAST spaces
    // later pulses REPEAT_RATE apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_tick   <= 1'b0;
            inc_dec    <= 1'b1;
            rep_active <= 1'b0;
            rep_cnt    <= '0;
        end else begin
            adj_tick <= 1'b0;
            if (state_next == ST_RUN || state_change) begin
                rep_active <= 1'b0;
                rep_cnt    <= '0;
                if (state_next == ST_RUN) inc_dec <= 1'b1;
            end else if (up_lvl && dn_lvl) begin
                rep_active <= 1'b0;
                rep_cnt    <= '0;
            end else if (up_press || dn_press) begin
                adj_tick   <= 1'b1;
                inc_dec    <= up_press;
                rep_active <= 1'b1;
                rep_cnt    <= RW'(1);
            end else if (rep_active && held_lvl) begin
                if (rep_cnt == REP_LAST) begin
                    adj_tick <= 1'b1;
                    rep_cnt  <= REP_RELOAD;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end else begin
                rep_active <= 1'b0;
                rep_cnt    <= '0;
            end
        end
    end

    assign tick = (run_tick | adj_tick) & ~state_change;

endmodule

// File: tb/tb_time_setup_ctrl.sv
// Scoreboard bench for time_setup_ctrl: expected tick cycles and directions
// are queued as stimulus is applied and matched as the DUT pulses tick.
module tb_time_setup_ctrl;

    localparam int TICK_DIV = 10;
    localparam int DEB      = 4;
    localparam int DELAY    = 20;
    localparam int RATE     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_mode = 1'b0, btn_select = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic display, setup_second, setup_minute, setup_hour, inc_dec, tick;

    time_setup_ctrl #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_select(btn_select),
        .btn_up(btn_up), .btn_down(btn_down),
        .display(display), .setup_second(setup_second),
        .setup_minute(setup_minute), .setup_hour(setup_hour),
        .inc_dec(inc_dec), .tick(tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   run_base = 0;
    int   pushed_to = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_tick(input int c, input logic d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        sb.push_back(e);
    endtask

    // Queue run-mode ticks for cycles [pushed_to, upto) given the current timebase origin.
    task automatic run_expect(input int upto);
        for (int c = pushed_to; c < upto; c++) begin
            if (c > run_base && ((c - run_base) % TICK_DIV) == TICK_DIV - 1) push_tick(c, 1'b1);
        end
        if (upto > pushed_to) pushed_to = upto;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_mode   = v;
            1: btn_select = v;
            2: btn_up     = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic tap(input int which);
        set_btn(which, 1'b1);
        wait_cycles(8);
        set_btn(which, 1'b0);
        wait_cycles(8);
    endtask

    logic tick_prev = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (tick) begin
            check("tick_back_to_back", tick_prev, 1'b0);
            if (sb.size() == 0) begin
                check("tick_unexpected", tick, 1'b0);
            end else begin
                e = sb.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_inc_dec", inc_dec, e.dir);
            end
        end
        tick_prev = tick;
    end

    int t0;
    int ev;

    initial begin
        wait_cycles(3);
        check("rst_display", display, 1'b0);
        check("rst_setup_second", setup_second, 1'b1);
        check("rst_setup_minute", setup_minute, 1'b1);
        check("rst_setup_hour", setup_hour, 1'b1);
        check("rst_inc_dec", inc_dec, 1'b1);
        check("rst_tick", tick, 1'b0);

        // Free-running timebase.
        rst = 1'b0;
        run_base = cyc;
        pushed_to = cyc + 1;
        run_expect(cyc + 36);
        wait_cycles(35);
        check("run_display", display, 1'b0);
        check("run_setup_second", setup_second, 1'b1);
        check("run_setup_minute", setup_minute, 1'b1);
        check("run_setup_hour", setup_hour, 1'b1);

        // Short glitch on mode must be rejected by the debouncer.
        run_expect(cyc + 13);
        btn_mode = 1'b1;
        wait_cycles(2);
        btn_mode = 1'b0;
        wait_cycles(10);
        check("glitch_display", display, 1'b0);

        // Real mode press: press event 6 cycles after the raw edge.
        t0 = cyc;
        run_expect(t0 + 6);
        btn_mode = 1'b1;
        wait_cycles(10);
        btn_mode = 1'b0;
        check("setup_display", display, 1'b1);
        check("setsec_second", setup_second, 1'b0);
        check("setsec_minute", setup_minute, 1'b1);
        check("setsec_hour", setup_hour, 1'b1);
        wait_cycles(12);

        // Field rotation.
        tap(1);
        tap(1);
        check("sel2_hour", setup_hour, 1'b0);
        check("sel2_second", setup_second, 1'b1);
        check("sel2_minute", setup_minute, 1'b1);
        tap(1);
        check("sel3_second", setup_second, 1'b0);
        check("sel3_hour", setup_hour, 1'b1);
        tap(1);
        check("setmin_minute", setup_minute, 1'b0);

        // Held up: press+1, then press+20 and every 5 after; released before press+40.
        t0 = cyc;
        ev = t0 + 6;
        push_tick(ev + 1, 1'b1);
        push_tick(ev + 20, 1'b1);
        push_tick(ev + 25, 1'b1);
        push_tick(ev + 30, 1'b1);
        push_tick(ev + 35, 1'b1);
        btn_up = 1'b1;
        wait_cycles(38);
        btn_up = 1'b0;
        wait_cycles(15);
        check("hold_up_still_min", setup_minute, 1'b0);
        check("hold_up_display", display, 1'b1);

        // Single down press.
        t0 = cyc;
        push_tick(t0 + 7, 1'b0);
        tap(3);
        check("down_inc_dec", inc_dec, 1'b0);

        // Both held: no ticks; dropping one must not look like a press.
        btn_up = 1'b1;
        btn_down = 1'b1;
        wait_cycles(30);
        btn_up = 1'b0;
        wait_cycles(25);
        btn_down = 1'b0;
        wait_cycles(12);
        check("both_display", display, 1'b1);

        // Back to run: first tick 10 cycles after the press event.
        t0 = cyc;
        run_base = t0 + 7;
        pushed_to = t0 + 7;
        run_expect(t0 + 31);
        btn_mode = 1'b1;
        wait_cycles(8);
        btn_mode = 1'b0;
        wait_cycles(22);
        check("ret_display", display, 1'b0);
        check("ret_inc_dec", inc_dec, 1'b1);
        check("ret_setup_minute", setup_minute, 1'b1);

        // Enter setup, hold down into auto-repeat, then reset.
        t0 = cyc;
        run_expect(t0 + 6);
        btn_mode = 1'b1;
        wait_cycles(8);
        btn_mode = 1'b0;
        wait_cycles(12);
        check("set2_second", setup_second, 1'b0);
        t0 = cyc;
        ev = t0 + 6;
        push_tick(ev + 1, 1'b0);
        push_tick(ev + 20, 1'b0);
        btn_down = 1'b1;
        wait_cycles(28);
        rst = 1'b1;
        #1;
        check("arst_display", display, 1'b0);
        check("arst_setup_second", setup_second, 1'b1);
        check("arst_inc_dec", inc_dec, 1'b1);
        check("arst_tick", tick, 1'b0);
        wait_cycles(3);
        rst = 1'b0;
        run_base = cyc;
        pushed_to = cyc + 1;
        run_expect(cyc + 31);
        wait_cycles(30);
        check("post_rst_display", display, 1'b0);
        check("post_rst_inc_dec", inc_dec, 1'b1);
        btn_down = 1'b0;
        run_expect(cyc + 13);
        wait_cycles(12);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_setup_ctrl.md
TIME_SETUP_CTRL -- requirements
Module: time_setup_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per 1 Hz timebase tick.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, stable cycles required to accept a button level.
REQ-003 Parameter REPEAT_DELAY, default 25000000, held cycles before auto-repeat starts.
REQ-004 Parameter REPEAT_RATE, default 5000000, cycles between auto-repeat adjust pulses.
REQ-005 clk  input  1  single system clock; all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 btn_mode  input  1  raw asynchronous button; enter/leave setup mode.
REQ-008 btn_select  input  1  raw button; cycles the field being set.
REQ-009 btn_up  input  1  raw button; increment selected field.
REQ-010 btn_down  input  1  raw button; decrement selected field.
REQ-011 display  output  1  0 = run (timekeeping), 1 = setup mode.
REQ-012 setup_second  output  1  active-low select of seconds field.
REQ-013 setup_minute  output  1  active-low select of minutes field.
REQ-014 setup_hour  output  1  active-low select of hours field.
REQ-015 inc_dec  output  1  1 = increment, 0 = decrement; qualifies tick in setup mode.
REQ-016 tick  output  1  one-cycle pulse: timebase tick in run mode, adjust pulse in setup mode.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples; a press event is a 0->1 edge of the debounced level, one cycle wide.
REQ-018 FSM states RUN, SET_SEC, SET_MIN, SET_HOUR; mode press: RUN->SET_SEC, any SET_*->RUN.
REQ-019 Select press in setup: SET_SEC->SET_MIN->SET_HOUR->SET_SEC; ignored in RUN.
REQ-020 Mode and select press in the same cycle: mode wins, select discarded.
REQ-021 display=0 only in RUN; exactly one setup_* low in the matching SET_* state, all high otherwise.
REQ-022 Timebase counter SHALL count 0..TICK_DIV-1 in RUN, wrap to 0, and assert tick for the one cycle at TICK_DIV-1.
REQ-023 In SET_* the timebase counter SHALL hold at 0; on return to RUN first tick occurs TICK_DIV cycles later.
REQ-024 In SET_*, an up (down) press SHALL produce one tick with inc_dec=1 (0) in the cycle after the press event.
REQ-025 While up (down) remains debounced-high, after REPEAT_DELAY cycles from the press, further ticks SHALL issue every REPEAT_RATE cycles with the same inc_dec.
REQ-026 Up and down both debounced-high: no adjust ticks; repeat counter cleared; releasing one does not generate a press.
REQ-027 Field change or leaving setup SHALL cancel any active repeat; tick SHALL never assert in the cycle of a state transition.
REQ-028 In RUN, up/down presses SHALL be ignored and inc_dec SHALL be held 1.
REQ-029 tick SHALL never be high two consecutive cycles.

Reset
REQ-030 rst SHALL force state RUN, display=0, setup_second/minute/hour=1, inc_dec=1, tick=0, all counters 0, debounced levels 0.
REQ-031 rst asserted mid-adjust or mid-debounce SHALL abort immediately; after release, a still-held button needs full DEBOUNCE_CYCLES and its 0->1 debounced edge counts as a press.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding and default parameter constants.
REQ-033 Sub-module btn_debounce (synchronizer, debounce counter, press-edge output) SHALL be instantiated four times.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-034 Reset released, no buttons -> tick pulses every 10 cycles, display=0, all setup_*=1.
REQ-035 btn_mode 2-cycle glitch -> no state change; held 10 cycles -> display=1, setup_second=0, no run ticks.
REQ-036 In SET_SEC, select pressed twice -> setup_hour=0; third press -> setup_second=0.
REQ-037 In SET_MIN, btn_up held 40 cycles -> tick at press+1, then at +20, +25, +30, +35, all with inc_dec=1.
REQ-038 btn_up and btn_down held together -> no tick; mode press -> RUN, next tick exactly 10 cycles later.
REQ-039 rst pulsed during auto-repeat with btn_down held -> outputs at reset values, state RUN, no tick until timebase expires.
